// File: rtl/accum_register_bank.sv
// Accumulator plus NUM_REGS-entry register bank behind a valid/ready command port,
// with registered compare flags, an error pulse and a multi-cycle bank clear.
module accum_register_bank #(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       NUM_REGS  = 8,
   parameter int unsigned       SEL_W     = 3,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op,
   input  logic [SEL_W-1:0]  reg_sel,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] res_val,
   output logic [DATA_W-1:0] reg_val,
   output logic              cmp_eq,
   output logic              cmp_lt,
   output logic              busy,
   output logic              err
);
   typedef enum logic [2:0] {
      OP_NOP    = 3'b000,
      OP_CPYIN  = 3'b001,
      OP_CPYOUT = 3'b010,
      OP_ALU    = 3'b011,
      OP_SWAP   = 3'b100,
      OP_CMP    = 3'b101,
      OP_CLEAR  = 3'b110,
      OP_ILL    = 3'b111
   } op_t;

   typedef enum logic {IDLE, CLR} state_t;

   localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W+1)'(NUM_REGS);
   localparam logic [SEL_W:0] LAST_IDX   = (SEL_W+1)'(NUM_REGS - 1);

   state_t            state, state_next;
   logic [SEL_W:0]    clr_idx;
   logic [DATA_W-1:0] regs [NUM_REGS];
   op_t               op_code;
   logic              accept, sel_ok, sel_op, bad_cmd;
   logic [DATA_W-1:0] sel_data;

   assign op_code  = op_t'(op);
   assign sel_ok   = {1'b0, reg_sel} < NUM_REGS_W;
   assign sel_data = sel_ok ? regs[reg_sel] : '0;
   assign reg_val  = sel_data;
   assign accept   = op_valid && op_ready;
   assign sel_op   = (op_code == OP_CPYIN) || (op_code == OP_CPYOUT) ||
                     (op_code == OP_SWAP)  || (op_code == OP_CMP);
   assign bad_cmd  = (op_code == OP_ILL) || (sel_op && !sel_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      op_ready   = (state == IDLE);
      busy       = (state == CLR);
      case (state)
         IDLE: if (accept && op_code == OP_CLEAR) state_next = CLR;
         CLR:  if (clr_idx == LAST_IDX) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Illegal commands are accepted (handshake completes) but only raise err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_val <= RESET_VAL;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
         cmp_eq  <= 1'b0;
         cmp_lt  <= 1'b0;
         err     <= 1'b0;
         clr_idx <= '0;
      end else begin
         err <= accept && bad_cmd;
         if (state == CLR) begin
            regs[clr_idx[SEL_W-1:0]] <= RESET_VAL;
            clr_idx <= clr_idx + 1'b1;
         end else if (accept && !bad_cmd) begin
            case (op_code)
               OP_CPYIN:  res_val <= sel_data;
               OP_CPYOUT: regs[reg_sel] <= res_val;
               OP_ALU:    res_val <= write_data;
               OP_SWAP: begin
                  res_val       <= sel_data;
                  regs[reg_sel] <= res_val;
               end
               OP_CMP: begin
                  cmp_eq <= (res_val == sel_data);
                  cmp_lt <= (res_val < sel_data);
               end
               OP_CLEAR:  clr_idx <= '0;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_accum_register_bank.sv
// Scoreboard bench for accum_register_bank: an 8-register instance carries the
// reference model, a 6-register instance on the same inputs covers out-of-range selects.
module tb_accum_register_bank;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op = '0;
   logic [2:0]  reg_sel = '0;
   logic [15:0] write_data = '0;

   logic        op_ready_a, cmp_eq_a, cmp_lt_a, busy_a, err_a;
   logic [15:0] res_val_a, reg_val_a;
   logic        op_ready_b, cmp_eq_b, cmp_lt_b, busy_b, err_b;
   logic [15:0] res_val_b, reg_val_b;

   accum_register_bank #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .RESET_VAL(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready_a), .op(op),
      .reg_sel(reg_sel), .write_data(write_data), .res_val(res_val_a), .reg_val(reg_val_a),
      .cmp_eq(cmp_eq_a), .cmp_lt(cmp_lt_a), .busy(busy_a), .err(err_a));

   accum_register_bank #(.DATA_W(16), .NUM_REGS(6), .SEL_W(3), .RESET_VAL(16'h0000)) dut6 (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready_b), .op(op),
      .reg_sel(reg_sel), .write_data(write_data), .res_val(res_val_b), .reg_val(reg_val_b),
      .cmp_eq(cmp_eq_b), .cmp_lt(cmp_lt_b), .busy(busy_b), .err(err_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_res;
   logic [15:0] m_regs [8];
   logic        m_eq, m_lt;

   typedef struct {
      logic [15:0] res;
      logic        err;
      logic        eq;
      logic        lt;
   } exp_t;
   exp_t sb_q[$];

   task automatic model_reset();
      m_res = '0;
      m_eq  = 1'b0;
      m_lt  = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      sb_q.delete();
   endtask

   task automatic sb_compare(input string tag);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb_q.pop_front();
      if (res_val_a !== e.res) begin
         errors++;
         $display("FAIL %s res_val: got %h expected %h", tag, res_val_a, e.res);
      end
      checks++;
      if (err_a !== e.err) begin
         errors++;
         $display("FAIL %s err: got %b expected %b", tag, err_a, e.err);
      end
      checks++;
      if (cmp_eq_a !== e.eq || cmp_lt_a !== e.lt) begin
         errors++;
         $display("FAIL %s flags eq/lt: got %b%b expected %b%b", tag, cmp_eq_a, cmp_lt_a, e.eq, e.lt);
      end
   endtask

   // Drive one command, wait for acceptance, update model, compare one cycle later.
   task automatic issue(input logic [2:0] o, input logic [2:0] s, input logic [15:0] d, input string tag);
      exp_t        e;
      logic [15:0] tmp;
      int          n = 0;
      @(negedge clk);
      op_valid = 1'b1; op = o; reg_sel = s; write_data = d;
      while (op_ready_a !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL %s ready timeout: got op_ready=%b expected 1", tag, op_ready_a);
            op_valid = 1'b0;
            return;
         end
      end
      e.err = 1'b0;
      case (o)
         3'd1: m_res = m_regs[s];
         3'd2: m_regs[s] = m_res;
         3'd3: m_res = d;
         3'd4: begin tmp = m_res; m_res = m_regs[s]; m_regs[s] = tmp; end
         3'd5: begin m_eq = (m_res == m_regs[s]); m_lt = (m_res < m_regs[s]); end
         3'd7: e.err = 1'b1;
         default: ;
      endcase
      e.res = m_res; e.eq = m_eq; e.lt = m_lt;
      sb_q.push_back(e);
      @(posedge clk); #1;
      op_valid = 1'b0;
      sb_compare(tag);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         reg_sel = 3'(i);
         #1;
         checks++;
         if (reg_val_a !== m_regs[i]) begin
            errors++;
            $display("FAIL %s reg%0d: got %h expected %h", tag, i, reg_val_a, m_regs[i]);
         end
      end
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      checks++;
      if (res_val_a !== 16'h0 || op_ready_a !== 1'b1 || busy_a !== 1'b0 ||
          err_a !== 1'b0 || cmp_eq_a !== 1'b0 || cmp_lt_a !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: got res=%h rdy=%b busy=%b err=%b eq=%b lt=%b expected 0000 1 0 0 0 0",
                  res_val_a, op_ready_a, busy_a, err_a, cmp_eq_a, cmp_lt_a);
      end
      check_regs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_alu_copy();
      issue(3'd3, 3'd0, 16'h1234, "alu_1234");
      issue(3'd2, 3'd5, 16'hFFFF, "cpyout5");
      reg_sel = 3'd5; #1;
      checks++;
      if (reg_val_a !== 16'h1234) begin
         errors++;
         $display("FAIL cpyout5 reg_val: got %h expected 1234", reg_val_a);
      end
      issue(3'd3, 3'd0, 16'h0001, "alu_0001");
      issue(3'd0, 3'd5, 16'hBEEF, "nop");
      issue(3'd1, 3'd5, 16'hBEEF, "cpyin5");
      check_regs("alu_copy");
   endtask

   task automatic test_swap();
      issue(3'd3, 3'd0, 16'h5555, "alu_5555");
      issue(3'd2, 3'd2, 16'h0, "cpyout2");
      issue(3'd3, 3'd0, 16'hAAAA, "alu_aaaa");
      issue(3'd4, 3'd2, 16'h0, "swap2");
      check_regs("swap");
   endtask

   task automatic test_cmp();
      issue(3'd3, 3'd0, 16'h0020, "alu_0020");
      issue(3'd2, 3'd1, 16'h0, "cpyout1");
      issue(3'd3, 3'd0, 16'h0010, "alu_0010");
      issue(3'd5, 3'd1, 16'h0, "cmp_lt");
      issue(3'd2, 3'd3, 16'h0, "cpyout3");
      issue(3'd5, 3'd3, 16'h0, "cmp_eq");
      issue(3'd3, 3'd0, 16'h0000, "flags_hold");
   endtask

   task automatic test_clear();
      exp_t e;
      int   n = 0;
      for (int i = 0; i < 8; i++) begin
         issue(3'd3, 3'd0, 16'h1000 + 16'(i), "load_alu");
         issue(3'd2, 3'(i), 16'h0, "load_cpyout");
      end
      issue(3'd3, 3'd0, 16'h4242, "alu_4242");
      check_regs("preclear");
      @(negedge clk);
      op_valid = 1'b1; op = 3'd6; reg_sel = 3'd5;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_res = 16'h7777;
      e.res = m_res; e.err = 1'b0; e.eq = m_eq; e.lt = m_lt;
      sb_q.push_back(e);
      @(negedge clk);
      op = 3'd3; write_data = 16'h7777;
      while (op_ready_a !== 1'b1 && n < 20) begin
         checks++;
         if (busy_a !== 1'b1 || res_val_a !== 16'h4242) begin
            errors++;
            $display("FAIL clear_busy cycle %0d: got busy=%b res=%h expected 1 4242", n, busy_a, res_val_a);
         end
         n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != 8 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL clear_len: got %0d cycles busy=%b expected 8 cycles busy=0", n, busy_a);
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      sb_compare("held_alu");
      check_regs("postclear");
   endtask

   task automatic test_illegal();
      issue(3'd2, 3'd6, 16'h0, "cpyout6");
      checks++;
      if (err_b !== 1'b1 || res_val_b !== 16'h7777) begin
         errors++;
         $display("FAIL n6_cpyout6: got err=%b res=%h expected 1 7777", err_b, res_val_b);
      end
      @(posedge clk); #1;
      checks++;
      if (err_b !== 1'b0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse_len: got err6=%b err8=%b expected 0 0", err_b, err_a);
      end
      for (int i = 0; i < 8; i++) begin
         reg_sel = 3'(i);
         #1;
         checks++;
         if (reg_val_b !== 16'h0) begin
            errors++;
            $display("FAIL n6_reg%0d: got %h expected 0000", i, reg_val_b);
         end
      end
      issue(3'd7, 3'd0, 16'hDEAD, "op111");
      checks++;
      if (err_b !== 1'b1 || res_val_b !== 16'h7777) begin
         errors++;
         $display("FAIL n6_op111: got err=%b res=%h expected 1 7777", err_b, res_val_b);
      end
      issue(3'd5, 3'd7, 16'h0, "cmp7");
      checks++;
      if (err_b !== 1'b1 || cmp_eq_b !== 1'b1 || cmp_lt_b !== 1'b0) begin
         errors++;
         $display("FAIL n6_cmp7: got err=%b eq=%b lt=%b expected 1 1 0", err_b, cmp_eq_b, cmp_lt_b);
      end
   endtask

   task automatic test_reset_mid_clear();
      issue(3'd3, 3'd0, 16'h00FF, "mid_alu");
      issue(3'd2, 3'd7, 16'h0, "mid_cpyout7");
      issue(3'd2, 3'd0, 16'h0, "mid_cpyout0");
      @(negedge clk);
      op_valid = 1'b1; op = 3'd6;
      @(posedge clk); #1;
      op_valid = 1'b0; reg_sel = 3'd7;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy_a !== 1'b1 || reg_val_a !== 16'h00FF) begin
         errors++;
         $display("FAIL mid_clear_live: got busy=%b reg7=%h expected 1 00ff", busy_a, reg_val_a);
      end
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (busy_a !== 1'b0 || op_ready_a !== 1'b1 || res_val_a !== 16'h0 || reg_val_a !== 16'h0 ||
          cmp_eq_a !== 1'b0 || cmp_lt_a !== 1'b0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b rdy=%b res=%h reg7=%h eq=%b lt=%b err=%b expected 0 1 0000 0000 0 0 0",
                  busy_a, op_ready_a, res_val_a, reg_val_a, cmp_eq_a, cmp_lt_a, err_a);
      end
      check_regs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'd3, 3'd0, 16'h0BEE, "post_reset_alu");
   endtask

   initial begin
      test_reset();
      test_alu_copy();
      test_swap();
      test_cmp();
      test_clear();
      test_illegal();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/accum_register_bank.md
Name: accum_register_bank

Overview:
- Parametrised accumulator-plus-register-bank for the datapath; successor of the 8x16 accumulator register file.
- Holds one accumulator (res) and NUM_REGS general registers, each DATA_W bits wide.
- Operations are issued through a valid/ready command interface: copy-in, copy-out, ALU writeback, swap, compare and a multi-cycle bank clear.
- Sits between the instruction decoder (commands) and the ALU (write_data in, res_val out).

Parameters:
- DATA_W, 16, width of res and of every register.
- NUM_REGS, 8, number of general registers; legal range 2..2**SEL_W.
- SEL_W, 3, width of reg_sel; must satisfy 2**SEL_W >= NUM_REGS.
- RESET_VAL, 0, value loaded into res and all registers on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  command present.
- op_ready  out  1  bank can accept a command this cycle.
- op  in  3  opcode, see Behaviour.
- reg_sel  in  SEL_W  register index for the command and for the reg_val read.
- write_data  in  DATA_W  ALU result.
- res_val  out  DATA_W  current accumulator, registered.
- reg_val  out  DATA_W  combinational read of reg[reg_sel].
- cmp_eq  out  1  registered compare result: res == reg.
- cmp_lt  out  1  registered compare result: res < reg, unsigned.
- busy  out  1  clear sequence in progress.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - res and all registers = RESET_VAL.
  - cmp_eq=0, cmp_lt=0, err=0, busy=0.
  - State = IDLE, op_ready=1.
  - Asserting reset mid-clear aborts the clear; the reset values apply immediately.
- Handshake:
  - A command is accepted when op_valid && op_ready at a rising edge.
  - Effects are visible the cycle after acceptance (1-cycle latency).
  - op_ready = (state==IDLE); it is a function of state only, never of op_valid.
- Opcodes (state changes occur only on acceptance):
  - 000 NOP: no change.
  - 001 CPYIN: res <= reg[sel].
  - 010 CPYOUT: reg[sel] <= res. Synchronous; res is unchanged.
  - 011 ALU: res <= write_data.
  - 100 SWAP: res <= reg[sel] and reg[sel] <= res in the same edge, both using pre-edge values.
  - 101 CMP: cmp_eq <= (res==reg[sel]); cmp_lt <= (res<reg[sel]). Flags hold until the next accepted CMP or reset.
  - 110 CLEAR: go to state CLR with clr_idx=0. reg_sel is ignored. res is not cleared.
  - 111: illegal; no state change, err pulses.
- Out-of-range reg_sel (sel >= NUM_REGS):
  - reg_val reads 0.
  - CPYIN, CPYOUT, SWAP and CMP have no effect and pulse err. In particular, CMP leaves the flags unchanged.
  - ALU, NOP and CLEAR are unaffected by reg_sel.
- err is registered: high for exactly one cycle after the offending acceptance, and 0 otherwise.
- State machine:
  - IDLE to CLR on accepted CLEAR.
  - In CLR, each cycle writes reg[clr_idx] <= RESET_VAL, then clr_idx += 1.
  - After writing index NUM_REGS-1, return to IDLE.
  - The clear takes exactly NUM_REGS cycles with op_ready=0 and busy=1 throughout; op_ready returns to 1 on the following cycle.
  - Commands presented during CLR are held off, not dropped; the requester keeps op_valid high.
  - reg_val stays live during CLR and shows partially cleared contents.
  - res_val and the compare flags are unaffected by CLR.
- No ALU writeback is taken unless an ALU command is accepted; write_data is otherwise ignored.
- Widths: no arithmetic is performed on data; the compare is unsigned across DATA_W bits. clr_idx is SEL_W+1 bits wide to avoid wrap when NUM_REGS = 2**SEL_W.

Test Plan:
1. Reset then ALU/CPYOUT/CPYIN:
   - Stimulus: ALU write_data=0x1234 -> res_val=0x1234 one cycle after; CPYOUT sel=5 -> reg_val(sel=5)=0x1234; ALU 0x0001; CPYIN sel=5.
   - Required: res_val=0x1234.
2. SWAP:
   - Stimulus: res=0xAAAA, reg2=0x5555; SWAP sel=2.
   - Required next cycle: res_val=0x5555 and reg2=0xAAAA.
3. CMP:
   - Stimulus: res=0x0010, reg1=0x0020; CMP sel=1.
   - Required: cmp_lt=1, cmp_eq=0.
   - Then CPYOUT sel=3 followed by CMP sel=3 -> cmp_eq=1, cmp_lt=0.
4. CLEAR with NUM_REGS=8:
   - Stimulus: load all registers nonzero, issue CLEAR, hold an ALU 0x7777 command on op_valid.
   - Required: op_ready=0 and busy=1 for exactly 8 cycles; all registers become 0; res is unchanged until the held ALU command is accepted on cycle 9; res_val=0x7777 afterwards.
5. Illegal commands with NUM_REGS=6, SEL_W=3:
   - Stimulus: CPYOUT sel=6.
   - Required: err pulses for 1 cycle, no register changes, reg_val(sel=7)=0.
   - Stimulus: op=111. Required: err pulses, no state change.
6. Reset mid-CLEAR:
   - Stimulus: drop rst_n at cycle 3 of a clear.
   - Required: busy=0, op_ready=1, all registers and res = RESET_VAL immediately, without waiting for a clock edge.
